// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, RISC-V funct3 access sizes, data width.
// Also holds the request legality helpers used at accept time.
package load_store_unit_pkg;

  localparam int LSU_DATA_W = 32;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_WRITE,
    LSU_RESP
  } lsu_state_t;

  typedef enum logic [2:0] {
    LSU_B  = 3'd0,
    LSU_H  = 3'd1,
    LSU_W  = 3'd2,
    LSU_BU = 3'd4,
    LSU_HU = 3'd5
  } mem_funct3_t;

  function automatic logic lsu_funct3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 <= 3'd2);
    return (f3 inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU});
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    return ((f3 == LSU_H || f3 == LSU_HU) && addr_lo[0]) ||
           ((f3 == LSU_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle of the load/store unit.
// master = core issuing requests, slave = load_store_unit.
interface load_store_unit_if
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_W-1:0]     req_addr;
  logic [LSU_DATA_W-1:0] req_wdata;
  logic                  resp_valid;
  logic [LSU_DATA_W-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane extraction/extension for loads and lane merge for SB/SH read-modify-write.
// Purely combinational, no handshake.
module load_store_unit_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [LSU_DATA_W-1:0] word,
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            funct3,
  input  logic [LSU_DATA_W-1:0] wdata,
  output logic [LSU_DATA_W-1:0] load_data,
  output logic [LSU_DATA_W-1:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    // addr[0] is deliberately ignored for halfwords
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (funct3)
      LSU_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  load_data = {24'h0, byte_sel};
      LSU_H:   load_data = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase

    store_word = wdata;
    case (funct3)
      LSU_B: begin
        store_word = word;
        case (addr_lo)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      LSU_H: begin
        store_word = word;
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a word-wide memory without byte enables (SB/SH via read-modify-write).
// Latency accept->resp_valid: load/SW 2, SB/SH 3, reject 1; req_ready only in IDLE, no resp backpressure.
// MISALIGN_TRAP_EN: reject misaligned H/W accesses instead of silently aligning them.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  load_store_unit_if.slave      lsu,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [LSU_DATA_W-1:0] mem_write_data,
  output logic                  mem_write_enable,
  input  logic [LSU_DATA_W-1:0] mem_read_data
);

  lsu_state_t            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [LSU_DATA_W-1:0] wdata_q, old_q, rdata_q;
  logic                  err_q;
  logic                  misalign, req_bad;
  logic [LSU_DATA_W-1:0] align_word, load_data, store_word;

`ifdef MISALIGN_TRAP_EN
  assign misalign = lsu_misaligned(lsu.req_funct3, lsu.req_addr[1:0]);
`else
  assign misalign = 1'b0;
`endif
  assign req_bad = !lsu_funct3_legal(lsu.req_we, lsu.req_funct3) || misalign;

  assign lsu.req_ready  = (state_q == LSU_IDLE);
  assign lsu.resp_valid = (state_q == LSU_RESP);
  assign lsu.resp_rdata = rdata_q;
  assign lsu.resp_err   = err_q;
  assign mem_address    = {addr_q[ADDR_W-1:2], 2'b00};

  // WRITE merges into the word captured in ACCESS; everything else sees the live read
  assign align_word = (state_q == LSU_WRITE) ? old_q : mem_read_data;

  load_store_unit_lane_align u_lane_align (
    .word       (align_word),
    .addr_lo    (addr_q[1:0]),
    .funct3     (funct3_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    case (state_q)
      LSU_IDLE: begin
        if (lsu.req_valid) state_d = req_bad ? LSU_RESP : LSU_ACCESS;
      end
      LSU_ACCESS: begin
        if (we_q && funct3_q != LSU_W) begin
          state_d = LSU_WRITE;
        end else begin
          state_d          = LSU_RESP;
          mem_write_enable = we_q;
          mem_write_data   = we_q ? store_word : '0;
        end
      end
      LSU_WRITE: begin
        state_d          = LSU_RESP;
        mem_write_enable = 1'b1;
        mem_write_data   = store_word;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // rdata_q/err_q are only written on the way into RESP, so they hold between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      wdata_q  <= '0;
      old_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (lsu.req_valid) begin
            addr_q   <= lsu.req_addr;
            we_q     <= lsu.req_we;
            funct3_q <= lsu.req_funct3;
            wdata_q  <= lsu.req_wdata;
            if (req_bad) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        LSU_ACCESS: begin
          if (!we_q) begin
            rdata_q <= load_data;
            err_q   <= 1'b0;
          end else if (funct3_q == LSU_W) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
          end else begin
            old_q <= mem_read_data;
          end
        end
        LSU_WRITE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model (comb read, posedge write).
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) intf ();

  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable;
  logic [31:0] mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_dat;
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lsu              (intf),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  assign mem_read_data = mem[mem_address[7:2]];
  wire unused_addr_bits = ^{mem_address[31:8], mem_address[1:0]};

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_address[7:2]] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_dat;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] dat);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_dat = dat;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Issue one request from idle; lat counts negedge samples after the accept edge.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er, output int nwr);
    int wr0;
    @(negedge clk);
    wr0 = wr_cnt;
    intf.req_valid = 1'b1; intf.req_we = we; intf.req_funct3 = f3;
    intf.req_addr = addr; intf.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    intf.req_valid = 1'b0;
    lat = 1;
    while (!intf.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rd = intf.resp_rdata;
    er = intf.resp_err;
    @(negedge clk);
    chk("resp_pulse_one_cycle", {31'b0, intf.resp_valid}, 32'd0);
    nwr = wr_cnt - wr0;
  endtask

  initial begin
    int lat, nwr, w0;
    logic [31:0] rd;
    logic er;
    intf.req_valid = 1'b0; intf.req_we = 1'b0; intf.req_funct3 = 3'd0;
    intf.req_addr = 32'h0; intf.req_wdata = 32'h0;
    bd_we = 1'b0; bd_idx = 6'd0; bd_dat = 32'h0;

    poke(6'd0, 32'hDEADBEEF);
    poke(6'd30, 32'hFFFFFFFF);

    // A store presented during reset must not be taken
    @(negedge clk);
    intf.req_valid = 1'b1; intf.req_we = 1'b1; intf.req_funct3 = 3'd2;
    intf.req_addr = 32'h78; intf.req_wdata = 32'h0BADF00D;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, intf.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, intf.resp_valid}, 32'd0);
    chk("rst_resp_rdata", intf.resp_rdata, 32'h0);
    chk("rst_resp_err", {31'b0, intf.resp_err}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_write_enable}, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    chk("rst_mem_addr", mem_address, 32'h0);
    intf.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_write", wr_cnt, 32'd0);
    chk("rst_mem30_intact", mem[30], 32'hFFFFFFFF);

    do_req(1'b0, 3'd2, 32'h0, 32'h0, lat, rd, er, nwr);
    chk("lw0_rdata", rd, 32'hDEADBEEF);
    chk("lw0_lat", lat, 32'd2);
    chk("lw0_err", {31'b0, er}, 32'd0);
    chk("lw0_nowrite", nwr, 32'd0);

    do_req(1'b0, 3'd7, 32'h0, 32'h0, lat, rd, er, nwr);
    chk("ld_f3_7_err", {31'b0, er}, 32'd1);
    chk("ld_f3_7_rdata", rd, 32'h0);
    chk("ld_f3_7_lat", lat, 32'd1);
    chk("ld_f3_7_hold_err", {31'b0, intf.resp_err}, 32'd1);

    do_req(1'b0, 3'd0, 32'h3, 32'h0, lat, rd, er, nwr);
    chk("lb3", rd, 32'hFFFFFFDE);
    chk("lb3_err", {31'b0, er}, 32'd0);
    do_req(1'b0, 3'd4, 32'h3, 32'h0, lat, rd, er, nwr);
    chk("lbu3", rd, 32'h000000DE);
    do_req(1'b0, 3'd4, 32'h1, 32'h0, lat, rd, er, nwr);
    chk("lbu1", rd, 32'h000000BE);
    do_req(1'b0, 3'd1, 32'h2, 32'h0, lat, rd, er, nwr);
    chk("lh2", rd, 32'hFFFFDEAD);
    do_req(1'b0, 3'd5, 32'h0, 32'h0, lat, rd, er, nwr);
    chk("lhu0", rd, 32'h0000BEEF);

    do_req(1'b1, 3'd0, 32'h79, 32'hAAAAAA55, lat, rd, er, nwr);
    chk("sb_mem", mem[30], 32'hFFFF55FF);
    chk("sb_lat", lat, 32'd3);
    chk("sb_writes", nwr, 32'd1);
    chk("sb_rdata", rd, 32'h0);
    do_req(1'b1, 3'd1, 32'h7A, 32'hFFFF1234, lat, rd, er, nwr);
    chk("sh_mem", mem[30], 32'h123455FF);
    chk("sh_lat", lat, 32'd3);
    chk("sh_writes", nwr, 32'd1);
    do_req(1'b1, 3'd2, 32'h78, 32'hCAFEBABE, lat, rd, er, nwr);
    chk("sw_mem", mem[30], 32'hCAFEBABE);
    chk("sw_lat", lat, 32'd2);
    chk("sw_writes", nwr, 32'd1);
    chk("sw_err", {31'b0, er}, 32'd0);

    // req_valid held high across two loads
    @(negedge clk);
    intf.req_valid = 1'b1; intf.req_we = 1'b0; intf.req_funct3 = 3'd2; intf.req_addr = 32'h0;
    @(posedge clk);
    @(negedge clk);
    intf.req_funct3 = 3'd5;
    chk("b2b_ready_access", {31'b0, intf.req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_ready_resp", {31'b0, intf.req_ready}, 32'd0);
    chk("b2b_resp1_valid", {31'b0, intf.resp_valid}, 32'd1);
    chk("b2b_resp1_rdata", intf.resp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("b2b_ready_idle", {31'b0, intf.req_ready}, 32'd1);
    chk("b2b_idle_no_resp", {31'b0, intf.resp_valid}, 32'd0);
    @(negedge clk);
    intf.req_valid = 1'b0;
    chk("b2b_second_taken", {31'b0, intf.req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b_resp2_valid", {31'b0, intf.resp_valid}, 32'd1);
    chk("b2b_resp2_rdata", intf.resp_rdata, 32'h0000BEEF);
    @(negedge clk);

    do_req(1'b1, 3'd3, 32'h78, 32'h11111111, lat, rd, er, nwr);
    chk("st_f3_3_err", {31'b0, er}, 32'd1);
    chk("st_f3_3_lat", lat, 32'd1);
    chk("st_f3_3_nowrite", nwr, 32'd0);
    chk("st_f3_3_mem", mem[30], 32'hCAFEBABE);

    // Reset while SB sits in WRITE
    @(negedge clk);
    w0 = wr_cnt;
    intf.req_valid = 1'b1; intf.req_we = 1'b1; intf.req_funct3 = 3'd0;
    intf.req_addr = 32'h78; intf.req_wdata = 32'h00000011;
    @(posedge clk);
    @(negedge clk);
    intf.req_valid = 1'b0;
    chk("rstw_access_no_we", {31'b0, mem_write_enable}, 32'd0);
    @(negedge clk);
    chk("rstw_write_we", {31'b0, mem_write_enable}, 32'd1);
    chk("rstw_write_data", mem_write_data, 32'hCAFEBA11);
    rst_n = 1'b0;
    #1;
    chk("rstw_we_killed", {31'b0, mem_write_enable}, 32'd0);
    @(negedge clk);
    chk("rstw_no_resp", {31'b0, intf.resp_valid}, 32'd0);
    chk("rstw_mem", mem[30], 32'hCAFEBABE);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstw_idle", {31'b0, intf.req_ready}, 32'd1);
    chk("rstw_no_resp_after", {31'b0, intf.resp_valid}, 32'd0);
    chk("rstw_nowrite", wr_cnt - w0, 32'd0);
    do_req(1'b0, 3'd2, 32'h78, 32'h0, lat, rd, er, nwr);
    chk("rstw_lw_after", rd, 32'hCAFEBABE);

`ifdef MISALIGN_TRAP_EN
    do_req(1'b0, 3'd2, 32'h2, 32'h0, lat, rd, er, nwr);
    chk("lw2_err", {31'b0, er}, 32'd1);
    chk("lw2_lat", lat, 32'd1);
    chk("lw2_rdata", rd, 32'h0);
    do_req(1'b0, 3'd1, 32'h1, 32'h0, lat, rd, er, nwr);
    chk("lh1_err", {31'b0, er}, 32'd1);
`else
    do_req(1'b0, 3'd2, 32'h2, 32'h0, lat, rd, er, nwr);
    chk("lw2_err", {31'b0, er}, 32'd0);
    chk("lw2_lat", lat, 32'd2);
    chk("lw2_rdata", rd, 32'hDEADBEEF);
    do_req(1'b0, 3'd1, 32'h1, 32'h0, lat, rd, er, nwr);
    chk("lh1_rdata", rd, 32'hFFFFBEEF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
